// File: rtl/ape_fetch_unit.sv
// Sequential instruction fetch with outstanding-request credits, redirect discard and a registered word FIFO.
// Optional macro APE_FETCH_ERR_HALT_EN: stop issuing requests after an error word until the next redirect.
module ape_fetch_unit #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        mem_req_o,
  output logic [31:0] mem_add_o,
  input  logic        mem_gnt_i,
  input  logic        mem_r_valid_i,
  input  logic [31:0] mem_r_rdata_i,
  input  logic        mem_r_opc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        ie_valid_o,
  input  logic        ie_ready_i,
  output logic [33:0] ie_data_o,
  output logic [31:0] ie_pc_o,
  output logic        busy_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [33:0]   fdata_q [FIFO_DEPTH];
  logic [31:0]   fpc_q   [FIFO_DEPTH];
  logic [31:0]   pcq_q   [4];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    outst_q, outst_d, kill_q, kill_d, pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  logic [31:0]   fa_q, fa_d, add_q, add_d, fa_base_s;
  logic          req_q, req_d, busy_q, busy_d, first_pend_q, first_pend_d, stale_q, stale_d;
  logic          fire_s, drop_s, push_s, pop_s, held_s, issue_s, halt_s;
`ifdef APE_FETCH_ERR_HALT_EN
  logic          halted_q, halted_d;
`endif

  // Next-state computation for counters, pointers, fetch address and request.
  always_comb begin
    fire_s    = req_q & mem_gnt_i;
    drop_s    = mem_r_valid_i & (kill_q != 2'd0);
    pop_s     = (cnt_q != '0) & ie_ready_i;
    push_s    = mem_r_valid_i & ~drop_s & ~redirect_i;
    held_s    = req_q & ~mem_gnt_i;
    fa_base_s = redirect_i ? (redirect_addr_i & 32'hFFFF_FFFC) : fa_q;
    outst_d   = outst_q + {1'b0, fire_s} - {1'b0, mem_r_valid_i};
    pq_wr_d   = pq_wr_q + {1'b0, fire_s};
    pq_rd_d   = pq_rd_q + {1'b0, mem_r_valid_i};
    // After a redirect everything still in flight is stale; a stalled old request joins at its grant.
    if (redirect_i) begin
      kill_d       = outst_d;
      stale_d      = held_s;
      cnt_d        = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      first_pend_d = 1'b1;
    end else begin
      kill_d       = kill_q - {1'b0, drop_s} + {1'b0, fire_s & stale_q};
      stale_d      = fire_s ? 1'b0 : stale_q;
      cnt_d        = cnt_q + CW'(push_s) - CW'(pop_s);
      rd_ptr_d     = rd_ptr_q + PW'(pop_s);
      wr_ptr_d     = wr_ptr_q + PW'(push_s);
      first_pend_d = push_s ? 1'b0 : first_pend_q;
    end
`ifdef APE_FETCH_ERR_HALT_EN
    if (redirect_i) begin
      halted_d = 1'b0;
    end else if (push_s & mem_r_opc_i) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
    halt_s = halted_d;
`else
    halt_s = 1'b0;
`endif
    issue_s = ~halt_s && (int'(outst_d) < MAX_OUTSTANDING)
              && ((int'(cnt_d) + int'(outst_d)) < FIFO_DEPTH);
    req_d   = held_s | issue_s;
    if (held_s) begin
      add_d = add_q;
      fa_d  = fa_base_s;
    end else if (issue_s) begin
      add_d = fa_base_s;
      fa_d  = fa_base_s + 32'd4;
    end else begin
      add_d = add_q;
      fa_d  = fa_base_s;
    end
    busy_d = (outst_d != 2'd0) | (kill_d != 2'd0);
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      outst_q      <= 2'd0;
      kill_q       <= 2'd0;
      pq_rd_q      <= 2'd0;
      pq_wr_q      <= 2'd0;
      fa_q         <= BOOT_ADDR;
      add_q        <= BOOT_ADDR;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      first_pend_q <= 1'b1;
      stale_q      <= 1'b0;
`ifdef APE_FETCH_ERR_HALT_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      outst_q      <= outst_d;
      kill_q       <= kill_d;
      pq_rd_q      <= pq_rd_d;
      pq_wr_q      <= pq_wr_d;
      fa_q         <= fa_d;
      add_q        <= add_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      first_pend_q <= first_pend_d;
      stale_q      <= stale_d;
`ifdef APE_FETCH_ERR_HALT_EN
      halted_q     <= halted_d;
`endif
    end
  end

  // Word FIFO storage and the PC queue of granted addresses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fdata_q[i] <= '0;
        fpc_q[i]   <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        pcq_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fdata_q[wr_ptr_q] <= {mem_r_opc_i, first_pend_q, mem_r_rdata_i};
        fpc_q[wr_ptr_q]   <= pcq_q[pq_rd_q];
      end
      if (fire_s) begin
        pcq_q[pq_wr_q] <= add_q;
      end
    end
  end

  assign mem_req_o  = req_q;
  assign mem_add_o  = add_q;
  assign busy_o     = busy_q;
  assign ie_valid_o = (cnt_q != '0);
  assign ie_data_o  = ie_valid_o ? fdata_q[rd_ptr_q] : 34'd0;
  assign ie_pc_o    = ie_valid_o ? fpc_q[rd_ptr_q] : 32'd0;
endmodule

// File: tb/tb_ape_fetch_unit.sv
// Directed bench for ape_fetch_unit: cycle table for fetch/back-pressure/redirect, plus stall, error and wrap sequences.
module tb_ape_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ni;

  logic a_gnt, a_rvalid, a_opc, a_redir, a_ready, a_req, a_valid, a_busy;
  logic [31:0] a_rdata, a_raddr, a_add, a_pc;
  logic [33:0] a_data;
  logic b_gnt, b_rvalid, b_opc, b_redir, b_ready, b_req, b_valid, b_busy;
  logic [31:0] b_rdata, b_raddr, b_add, b_pc;
  logic [33:0] b_data;

  ape_fetch_unit #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .BOOT_ADDR(32'h0000_0100)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .mem_req_o(a_req), .mem_add_o(a_add), .mem_gnt_i(a_gnt),
    .mem_r_valid_i(a_rvalid), .mem_r_rdata_i(a_rdata), .mem_r_opc_i(a_opc),
    .redirect_i(a_redir), .redirect_addr_i(a_raddr), .ie_valid_o(a_valid), .ie_ready_i(a_ready),
    .ie_data_o(a_data), .ie_pc_o(a_pc), .busy_o(a_busy));

  ape_fetch_unit #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .BOOT_ADDR(32'hFFFF_FFF8)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .mem_req_o(b_req), .mem_add_o(b_add), .mem_gnt_i(b_gnt),
    .mem_r_valid_i(b_rvalid), .mem_r_rdata_i(b_rdata), .mem_r_opc_i(b_opc),
    .redirect_i(b_redir), .redirect_addr_i(b_raddr), .ie_valid_o(b_valid), .ie_ready_i(b_ready),
    .ie_data_o(b_data), .ie_pc_o(b_pc), .busy_o(b_busy));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        ready, gnt, rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] raddr;
    logic        e_req;
    logic [31:0] e_add;
    logic        e_valid;
    logic [33:0] e_data;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(logic ready, logic gnt, logic rvalid, logic [31:0] rdata,
                              logic redir, logic [31:0] raddr, logic e_req, logic [31:0] e_add,
                              logic e_valid, logic [33:0] e_data, logic [31:0] e_pc, logic e_busy);
    vec_t v;
    v.ready = ready; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.redir = redir;
    v.raddr = raddr; v.e_req = e_req; v.e_add = e_add; v.e_valid = e_valid;
    v.e_data = e_data; v.e_pc = e_pc; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic zero_inputs();
    a_gnt = 1'b0; a_rvalid = 1'b0; a_opc = 1'b0; a_redir = 1'b0; a_ready = 1'b1;
    a_rdata = 32'd0; a_raddr = 32'd0;
    b_gnt = 1'b0; b_rvalid = 1'b0; b_opc = 1'b0; b_redir = 1'b0; b_ready = 1'b1;
    b_rdata = 32'd0; b_raddr = 32'd0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  logic [31:0] a_iss[$], b_iss[$], a_pcs[$];
  logic [33:0] a_dat[$];
  logic        a_lf, b_lf;
  logic [31:0] a_la, b_la;

  initial begin
    // ready, gnt, rvalid, rdata, redir, raddr | req, add, valid, data, pc, busy
    vt[0]  = mk(1'b1, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0,      1'b1, 32'h100,  1'b0, 34'd0,           32'd0,     1'b0);
    vt[1]  = mk(1'b1, 1'b1, 1'b1, 32'hC0DE0100,  1'b0, 32'd0,      1'b1, 32'h104,  1'b0, 34'd0,           32'd0,     1'b1);
    vt[2]  = mk(1'b1, 1'b1, 1'b1, 32'hC0DE0104,  1'b0, 32'd0,      1'b1, 32'h108,  1'b1, 34'h1_C0DE_0100, 32'h100,   1'b1);
    vt[3]  = mk(1'b0, 1'b1, 1'b1, 32'hC0DE0108,  1'b0, 32'd0,      1'b1, 32'h10C,  1'b1, 34'h0_C0DE_0104, 32'h104,   1'b1);
    vt[4]  = mk(1'b0, 1'b1, 1'b1, 32'hC0DE010C,  1'b0, 32'd0,      1'b1, 32'h110,  1'b1, 34'h0_C0DE_0104, 32'h104,   1'b1);
    vt[5]  = mk(1'b0, 1'b0, 1'b1, 32'hC0DE0110,  1'b0, 32'd0,      1'b0, 32'd0,    1'b1, 34'h0_C0DE_0104, 32'h104,   1'b1);
    vt[6]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'd0,      1'b0, 32'd0,    1'b1, 34'h0_C0DE_0104, 32'h104,   1'b0);
    vt[7]  = mk(1'b1, 1'b0, 1'b0, 32'd0,         1'b0, 32'd0,      1'b0, 32'd0,    1'b1, 34'h0_C0DE_0104, 32'h104,   1'b0);
    vt[8]  = mk(1'b1, 1'b0, 1'b0, 32'd0,         1'b0, 32'd0,      1'b1, 32'h114,  1'b1, 34'h0_C0DE_0108, 32'h108,   1'b0);
    vt[9]  = mk(1'b1, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0,      1'b1, 32'h114,  1'b1, 34'h0_C0DE_010C, 32'h10C,   1'b0);
    vt[10] = mk(1'b1, 1'b0, 1'b0, 32'd0,         1'b0, 32'd0,      1'b1, 32'h118,  1'b1, 34'h0_C0DE_0110, 32'h110,   1'b1);
    vt[11] = mk(1'b1, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0,      1'b1, 32'h118,  1'b0, 34'd0,           32'd0,     1'b1);
    vt[12] = mk(1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'h2000,   1'b0, 32'd0,    1'b0, 34'd0,           32'd0,     1'b1);
    vt[13] = mk(1'b1, 1'b0, 1'b1, 32'hC0DE0114,  1'b0, 32'd0,      1'b0, 32'd0,    1'b0, 34'd0,           32'd0,     1'b1);
    vt[14] = mk(1'b1, 1'b0, 1'b1, 32'hC0DE0118,  1'b0, 32'd0,      1'b1, 32'h2000, 1'b0, 34'd0,           32'd0,     1'b1);
    vt[15] = mk(1'b1, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0,      1'b1, 32'h2000, 1'b0, 34'd0,           32'd0,     1'b0);
    vt[16] = mk(1'b0, 1'b0, 1'b1, 32'hC0DE2000,  1'b0, 32'd0,      1'b1, 32'h2004, 1'b0, 34'd0,           32'd0,     1'b1);
    vt[17] = mk(1'b1, 1'b0, 1'b0, 32'd0,         1'b0, 32'd0,      1'b1, 32'h2004, 1'b1, 34'h1_C0DE_2000, 32'h2000,  1'b0);

    rst_ni = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    chk("rst_req",   a_req,   1'b0);
    chk("rst_add",   a_add,   32'h100);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_data",  a_data,  34'd0);
    chk("rst_pc",    a_pc,    32'd0);
    chk("rst_busy",  a_busy,  1'b0);
    chk("rst_add_b", b_add,   32'hFFFF_FFF8);
    rst_ni = 1'b1;

    // Straight-line fetch, back-pressure and release, redirect with two outstanding.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i), a_req, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("v%0d_add", i), a_add, vt[i].e_add);
      chk($sformatf("v%0d_valid", i), a_valid, vt[i].e_valid);
      chk($sformatf("v%0d_data", i), a_data, vt[i].e_data);
      chk($sformatf("v%0d_pc", i), a_pc, vt[i].e_pc);
      chk($sformatf("v%0d_busy", i), a_busy, vt[i].e_busy);
      a_ready = vt[i].ready; a_gnt = vt[i].gnt; a_rvalid = vt[i].rvalid;
      a_rdata = vt[i].rdata; a_redir = vt[i].redir; a_raddr = vt[i].raddr;
    end

    // Redirect while the request is stalled: old address held until grant, its response dropped.
    do_reset();
    @(negedge clk);
    chk("st_first_req", a_req, 1'b1);
    chk("st_first_add", a_add, 32'h100);
    a_redir = 1'b1; a_raddr = 32'h83; a_gnt = 1'b0;
    @(negedge clk);
    a_redir = 1'b0;
    chk("st_hold_req", a_req, 1'b1);
    chk("st_hold_add", a_add, 32'h100);
    chk("st_hold_busy", a_busy, 1'b0);
    a_gnt = 1'b1;
    @(negedge clk);
    chk("st_new_req", a_req, 1'b1);
    chk("st_new_add", a_add, 32'h80);
    chk("st_kill_busy", a_busy, 1'b1);
    a_gnt = 1'b0; a_rvalid = 1'b1; a_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_drop_valid", a_valid, 1'b0);
    chk("st_drop_busy", a_busy, 1'b0);
    chk("st_drop_add", a_add, 32'h80);
    a_rvalid = 1'b0; a_gnt = 1'b1;
    @(negedge clk);
    a_gnt = 1'b0; a_rvalid = 1'b1; a_rdata = 32'hC0DE_0080;
    @(negedge clk);
    a_rvalid = 1'b0;
    chk("st_word_valid", a_valid, 1'b1);
    chk("st_word_data", a_data, 34'h1_C0DE_0080);
    chk("st_word_pc", a_pc, 32'h80);

    // Error word at 0x108 on A and address wrap on B; memory grants always, responds next cycle.
    do_reset();
    a_gnt = 1'b1; b_gnt = 1'b1;
    a_lf = 1'b0; b_lf = 1'b0; a_la = 32'd0; b_la = 32'd0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (a_valid) begin a_pcs.push_back(a_pc); a_dat.push_back(a_data); end
      if (a_req) a_iss.push_back(a_add);
      if (b_req) b_iss.push_back(b_add);
      a_rvalid = a_lf; a_rdata = 32'hC0DE_0000 | a_la; a_opc = a_lf && (a_la == 32'h108);
      b_rvalid = b_lf; b_rdata = b_la;
      a_lf = a_req; a_la = a_add;
      b_lf = b_req; b_la = b_add;
    end
    a_rvalid = 1'b0; b_rvalid = 1'b0; a_opc = 1'b0;
    chk("err_npcs_ge4", a_pcs.size() >= 4, 1'b1);
    if (a_pcs.size() >= 4) begin
      chk("err_pc0", a_pcs[0], 32'h100);
      chk("err_pc2", a_pcs[2], 32'h108);
      chk("err_pc3", a_pcs[3], 32'h10C);
      chk("err_dat0", a_dat[0], 34'h1_C0DE_0100);
      chk("err_dat2", a_dat[2], 34'h2_C0DE_0108);
      chk("err_dat3", a_dat[3], 34'h0_C0DE_010C);
    end
    chk("wrap_n", b_iss.size() >= 3, 1'b1);
    if (b_iss.size() >= 3) begin
      chk("wrap_a0", b_iss[0], 32'hFFFF_FFF8);
      chk("wrap_a1", b_iss[1], 32'hFFFF_FFFC);
      chk("wrap_a2", b_iss[2], 32'h0000_0000);
    end
`ifdef APE_FETCH_ERR_HALT_EN
    chk("halt_niss", a_iss.size(), 4);
    chk("halt_req", a_req, 1'b0);
    a_gnt = 1'b0; a_redir = 1'b1; a_raddr = 32'h300;
    @(negedge clk);
    a_redir = 1'b0;
    chk("halt_resume_req", a_req, 1'b1);
    chk("halt_resume_add", a_add, 32'h300);
`else
    chk("cont_niss", a_iss.size() >= 5, 1'b1);
    if (a_iss.size() >= 5) chk("cont_iss4", a_iss[4], 32'h110);
    chk("cont_req", a_req, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
